// File: rtl/seg7_pkg.sv
// Shared constants for the multiplexed 7-segment display: active-low segment
// patterns {g,f,e,d,c,b,a} and the scan state encoding.
package seg7_pkg;

   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHOW  = 2'd1,
      GUARD = 2'd2
   } scan_state_t;

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low 7-segment decoder; non-BCD nibbles
// render as a dash.
module bcd_to_seg7
   import seg7_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   always_comb begin
      case (bcd)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/seg7_scan_display.sv
// Time-multiplexed common-anode display scanner with guard interval and
// frame-coherent digit snapshot. Define SEG7_BLANK_EN for leading-zero blanking.
module seg7_scan_display
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS   = 4,
   parameter int REFRESH_DIV  = 50000,
   parameter int GUARD_CYCLES = 500
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      enable,
   input  logic [4*NUM_DIGITS-1:0]   digits,
   input  logic [NUM_DIGITS-1:0]     dp_mask,
   output logic [NUM_DIGITS-1:0]     an,
   output logic [6:0]                seg,
   output logic                      dp,
   output logic                      frame_tick
);

   localparam int CNT_W = $clog2(REFRESH_DIV);
   localparam int IDX_W = $clog2(NUM_DIGITS);

   localparam logic [CNT_W-1:0] SHOW_END = CNT_W'(REFRESH_DIV - GUARD_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_END = CNT_W'(REFRESH_DIV - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   scan_state_t               state_reg, state_next;
   logic [CNT_W-1:0]          cnt_reg, cnt_next;
   logic [IDX_W-1:0]          idx_reg, idx_next;
   logic [4*NUM_DIGITS-1:0]   snap_reg, snap_next;
   logic [NUM_DIGITS-1:0]     dps_reg, dps_next;

   logic [NUM_DIGITS-1:0]     an_next;
   logic [6:0]                seg_next;
   logic                      dp_next;
   logic                      tick_next;

   logic [3:0]                cur_digit;
   logic [6:0]                cur_seg;
   logic [NUM_DIGITS-1:0]     blank;

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      idx_next   = idx_reg;
      snap_next  = snap_reg;
      dps_next   = dps_reg;
      tick_next  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (enable) begin
               state_next = SHOW;
               cnt_next   = '0;
               idx_next   = '0;
               snap_next  = digits;
               dps_next   = dp_mask;
            end
         end
         SHOW: begin
            if (!enable) begin
               state_next = IDLE;
               cnt_next   = '0;
               idx_next   = '0;
            end else begin
               cnt_next = cnt_reg + 1'b1;
               if (cnt_reg == SHOW_END)
                  state_next = GUARD;
            end
         end
         GUARD: begin
            if (!enable) begin
               state_next = IDLE;
               cnt_next   = '0;
               idx_next   = '0;
            end else if (cnt_reg == SLOT_END) begin
               state_next = SHOW;
               cnt_next   = '0;
               if (idx_reg == LAST_IDX) begin
                  // Frame boundary: the only point where new input values are taken.
                  idx_next  = '0;
                  snap_next = digits;
                  dps_next  = dp_mask;
                  tick_next = 1'b1;
               end else begin
                  idx_next = idx_reg + 1'b1;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
            idx_next   = '0;
         end
      endcase
   end

   // Outputs are derived from next-state values so they change on the same edge.
   assign cur_digit = snap_next[4*idx_next +: 4];

   bcd_to_seg7 u_dec (
      .bcd (cur_digit),
      .seg (cur_seg)
   );

`ifdef SEG7_BLANK_EN
   assign blank[0] = 1'b0;
   generate
      for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_blank
         assign blank[gi] = (snap_next[4*NUM_DIGITS-1 : 4*gi] == '0);
      end
   endgenerate
`else
   assign blank = '0;
`endif

   always_comb begin
      an_next  = '1;
      seg_next = SEG_OFF;
      dp_next  = 1'b1;
      if (state_next == SHOW) begin
         an_next[idx_next] = 1'b0;
         seg_next          = blank[idx_next] ? SEG_OFF : cur_seg;
         dp_next           = ~dps_next[idx_next];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg  <= IDLE;
         cnt_reg    <= '0;
         idx_reg    <= '0;
         snap_reg   <= '0;
         dps_reg    <= '0;
         an         <= '1;
         seg        <= SEG_OFF;
         dp         <= 1'b1;
         frame_tick <= 1'b0;
      end else begin
         state_reg  <= state_next;
         cnt_reg    <= cnt_next;
         idx_reg    <= idx_next;
         snap_reg   <= snap_next;
         dps_reg    <= dps_next;
         an         <= an_next;
         seg        <= seg_next;
         dp         <= dp_next;
         frame_tick <= tick_next;
      end
   end

endmodule

// File: tb/tb_seg7_scan_display.sv
// Scoreboard bench for seg7_scan_display: a frame-position model predicts every
// cycle's outputs, a monitor process compares them after each clock edge.
module tb_seg7_scan_display;

   localparam int ND    = 4;
   localparam int RDIV  = 8;
   localparam int GUARD = 2;
   localparam int FRAME = ND * RDIV;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          enable = 1'b0;
   logic [15:0]   digits = 16'h0000;
   logic [3:0]    dp_mask = 4'b0000;
   logic [3:0]    an;
   logic [6:0]    seg;
   logic          dp;
   logic          frame_tick;

   typedef struct packed {
      logic [3:0] an;
      logic [6:0] seg;
      logic       dp;
      logic       tick;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   fails  = 0;

   // Behavioural model: position in cycles since the display was started.
   bit          m_active = 0;
   int          m_pos = 0;
   logic [15:0] m_snap = 16'h0;
   logic [3:0]  m_dps = 4'h0;
   bit          m_tick = 0;

   always #5 clk = ~clk;

   seg7_scan_display #(
      .NUM_DIGITS   (ND),
      .REFRESH_DIV  (RDIV),
      .GUARD_CYCLES (GUARD)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .digits     (digits),
      .dp_mask    (dp_mask),
      .an         (an),
      .seg        (seg),
      .dp         (dp),
      .frame_tick (frame_tick)
   );

   function automatic logic [6:0] ref_seg(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;  4'd1: return 7'h79;
         4'd2: return 7'h24;  4'd3: return 7'h30;
         4'd4: return 7'h19;  4'd5: return 7'h12;
         4'd6: return 7'h02;  4'd7: return 7'h78;
         4'd8: return 7'h00;  4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction

   function automatic exp_t model_out();
      exp_t e;
      int   slot;
      bit   bl;
      e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1; e.tick = m_tick;
      if (m_active && (m_pos % RDIV) < (RDIV - GUARD)) begin
         slot = (m_pos / RDIV) % ND;
         bl = 0;
`ifdef SEG7_BLANK_EN
         for (int k = ND - 1; k >= 1; k--) begin
            if (m_snap[k*4 +: 4] != 4'd0) break;
            if (k == slot) bl = 1;
         end
`endif
         e.an        = 4'hF;
         e.an[slot]  = 1'b0;
         e.seg       = bl ? 7'h7F : ref_seg(m_snap[slot*4 +: 4]);
         e.dp        = ~m_dps[slot];
      end
      return e;
   endfunction

   // Advance the model by one clock edge using the inputs now applied, queue the
   // expected result, and move on to the following falling edge.
   task automatic step();
      m_tick = 0;
      if (reset) begin
         m_active = 0; m_pos = 0; m_snap = 16'h0; m_dps = 4'h0;
      end else if (!m_active) begin
         if (enable) begin
            m_active = 1; m_pos = 0; m_snap = digits; m_dps = dp_mask;
         end
      end else if (!enable) begin
         m_active = 0; m_pos = 0;
      end else begin
         m_pos++;
         if (m_pos % FRAME == 0) begin
            m_snap = digits; m_dps = dp_mask; m_tick = 1;
         end
      end
      q.push_back(model_out());
      @(negedge clk);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   function automatic logic [15:0] rand_digits();
      logic [15:0] v;
      for (int k = 0; k < ND; k++)
         v[k*4 +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      return v;
   endfunction

   // Monitor: every edge presents one output word, compared against the queue head.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if ({an, seg, dp, frame_tick} !== e) begin
               fails++;
               $display("FAIL scan_output t=%0t got an=%h seg=%h dp=%b tick=%b want an=%h seg=%h dp=%b tick=%b",
                        $time, an, seg, dp, frame_tick, e.an, e.seg, e.dp, e.tick);
            end
         end
      end
   end

   initial begin
      int guard_cnt;

      run(5);
      reset = 1'b0;
      $display("phase reset_release: enable low for 20 cycles");
      run(20);

      $display("phase count: digits=1234 dp_mask=0100");
      enable = 1'b1; digits = 16'h1234; dp_mask = 4'b0100;
      run(10);
      $display("phase midframe_change: digits=5678 at frame cycle 10");
      digits = 16'h5678;
      run(60);

      $display("phase dash: digits=00C0");
      digits = 16'h00C0; dp_mask = 4'b0000;
      run(2 * FRAME);

      $display("phase leading_zero: digits=0070");
      digits = 16'h0070; dp_mask = 4'b1001;
      run(2 * FRAME);

      $display("phase enable_drop: drop during SHOW of digit 2");
      guard_cnt = 0;
      while (!(m_active && (m_pos % FRAME) == 2 * RDIV + 1) && guard_cnt < 200) begin
         step(); guard_cnt++;
      end
      checks++;
      if (guard_cnt >= 200) begin
         fails++;
         $display("FAIL reach_digit2 got timeout=%0d want <200", guard_cnt);
      end
      enable = 1'b0;
      run(3);
      digits = 16'h9087; dp_mask = 4'b0010; enable = 1'b1;
      run(FRAME + 5);

      $display("phase async_reset: reset asserted in GUARD");
      guard_cnt = 0;
      while (!(m_active && (m_pos % RDIV) == RDIV - GUARD) && guard_cnt < 200) begin
         step(); guard_cnt++;
      end
      #2;
      reset = 1'b1;
      #1;
      checks++;
      if ({an, seg, dp, frame_tick} !== {4'hF, 7'h7F, 1'b1, 1'b0}) begin
         fails++;
         $display("FAIL async_reset got an=%h seg=%h dp=%b tick=%b want an=f seg=7f dp=1 tick=0",
                  an, seg, dp, frame_tick);
      end
      m_active = 0; m_pos = 0; m_snap = 16'h0; m_dps = 4'h0; m_tick = 0;
      @(negedge clk);
      run(3);
      reset = 1'b0;
      run(5);

      $display("phase random: 600 cycles of randomized stimulus");
      digits = rand_digits(); dp_mask = 4'($urandom_range(0, 15));
      for (int i = 0; i < 600; i++) begin
         if ($urandom_range(0, 12) == 0) digits = rand_digits();
         if ($urandom_range(0, 20) == 0) dp_mask = 4'($urandom_range(0, 15));
         enable = ($urandom_range(0, 150) != 0);
         step();
      end

      @(posedge clk);
      #2;
      checks++;
      if (q.size() != 0) begin
         fails++;
         $display("FAIL queue_drain got %0d pending want 0", q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
